// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg
// Shared definitions for the select-decode family (decoder, future demux and
// arbiter blocks): mode encodings, the widest supported select, and a one-hot
// helper that returns a MAX_N-wide vector for callers to truncate.
package scan_decoder_pkg;

  localparam int MAX_SEL_W = 5;
  localparam int MAX_N     = 1 << MAX_SEL_W;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Bit 'sel' set. Selects at or beyond 2**width yield all zeros.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                              input int width);
    logic [MAX_N-1:0] r;
    r = '0;
    if (int'(sel) < (1 << width)) r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if
// Control/observe bundle for scan_decoder.
//   en, mode, load, sel_in : controller -> decoder
//   dec_out, sel_q, valid, wrap : decoder -> controller
// master = controller side, slave = decoder side.
interface scan_decoder_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] sel_in;
  logic [N-1:0]     dec_out;
  logic [SEL_W-1:0] sel_q;
  logic             valid;
  logic             wrap;

  modport master (
    output en, mode, load, sel_in,
    input  dec_out, sel_q, valid, wrap
  );

  modport slave (
    input  en, mode, load, sel_in,
    output dec_out, sel_q, valid, wrap
  );

endinterface

// File: rtl/scan_decoder_dwell_counter.sv
// dwell_counter
// Counts 0..DWELL-1 while run=1 and wraps to 0. tick flags the last count
// of a dwell period so the owner can advance on that edge.
//   clk   : clock
//   rst   : synchronous active-high reset
//   run   : count enable; when low the count is held at 0
//   clear : force the count back to 0 on the next edge
//   tick  : count == DWELL-1 and run
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !run) cnt <= '0;
    else if (cnt == LAST)     cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder
// Registered binary-to-one-hot decoder with a latched select, output enable
// and a self-running scan mode that steps through every output, DWELL cycles
// each.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : scan_decoder_if.slave
//          en      output enable (gates dec_out/valid only)
//          mode    0 direct, 1 scan
//          load    capture sel_in into sel_q
//          sel_in  select value
//          dec_out registered one-hot of sel_q, inverted when ACTIVE_LOW
//          sel_q   select register
//          valid   registered en
//          wrap    one-cycle pulse on the scan step from N-1 to 0
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave bus
);
  localparam int           N        = 1 << SEL_W;
  localparam logic [N-1:0] INACTIVE = {N{ACTIVE_LOW}};

  logic             scan;
  logic             tick;
  logic [SEL_W-1:0] sel_r, sel_nxt;
  logic             wrap_nxt;
  logic [N-1:0]     oh_nxt;
  logic [N-1:0]     dec_r;
  logic             valid_r, wrap_r;

  assign scan = (bus.mode == MODE_SCAN);

  // A load also clears the dwell count so the loaded output gets a full dwell.
  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .run   (scan),
    .clear (bus.load),
    .tick  (tick)
  );

  // load wins over a scan step landing on the same edge.
  always_comb begin
    sel_nxt  = sel_r;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      sel_nxt = bus.sel_in;
    end else if (scan && tick) begin
      sel_nxt  = sel_r + 1'b1;
      wrap_nxt = (sel_r == '1);
    end
  end

  // Decode from the next-state select so dec_out tracks sel_q on the same edge.
  assign oh_nxt = N'(onehot(MAX_SEL_W'(sel_nxt), SEL_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r   <= '0;
      dec_r   <= INACTIVE;
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      sel_r   <= sel_nxt;
      wrap_r  <= wrap_nxt;
      valid_r <= bus.en;
      dec_r   <= bus.en ? (oh_nxt ^ INACTIVE) : INACTIVE;
    end
  end

  assign bus.sel_q   = sel_r;
  assign bus.dec_out = dec_r;
  assign bus.valid   = valid_r;
  assign bus.wrap    = wrap_r;

endmodule
